rob_nway: RTL and testbench

ROB_NWAY -- requirements
Module: rob_nway

---
 rtl/sys_defs.sv | 22 ++
 rtl/rob_nway_retire_sel.sv | 37 +++
 rtl/rob_nway.sv | 183 ++++++++++++++++++
 tb/tb_rob_nway.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the reorder buffer slice.
// Holds the default lane count, entry count and data width, and the
// ROB_ENTRY record stored in every reorder-buffer slot.
package sys_defs;

  localparam int unsigned SYS_WAYS     = 2;
  localparam int unsigned SYS_ROB_SIZE = 32;
  localparam int unsigned SYS_XLEN     = 32;

  // One reorder-buffer slot. The data fields use the default width, so a
  // rob_nway instance is expected to keep XLEN equal to SYS_XLEN.
  typedef struct packed {
    logic                valid;
    logic                completed;
    logic                mispred;
    logic [SYS_XLEN-1:0] pc;
    logic [4:0]          dest_idx;
    logic [SYS_XLEN-1:0] value;
    logic [SYS_XLEN-1:0] target;
  } ROB_ENTRY;

endpackage

// File: rtl/rob_nway_retire_sel.sv
// In-order retire selector over the WAYS oldest reorder-buffer entries.
// Ports:
//   head_valid/head_completed/head_mispred : flags of entries head..head+WAYS-1
//   retire     : lane k retires (all older lanes retired, entry done, no older mispredict)
//   squash_sel : one-hot marker of the retiring lane that carries a mispredict
module rob_retire_sel #(
  parameter int unsigned WAYS = 2
) (
  input  logic [WAYS-1:0] head_valid,
  input  logic [WAYS-1:0] head_completed,
  input  logic [WAYS-1:0] head_mispred,
  output logic [WAYS-1:0] retire,
  output logic [WAYS-1:0] squash_sel
);

  logic blocked;

  // A lane that is not ready, or a retiring mispredicted lane, blocks every
  // younger lane for the rest of the cycle.
  always_comb begin
    retire     = '0;
    squash_sel = '0;
    blocked    = 1'b0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (!blocked && head_valid[k] && head_completed[k]) begin
        retire[k] = 1'b1;
        if (head_mispred[k]) begin
          squash_sel[k] = 1'b1;
          blocked       = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: WAYS dispatch, completion and retirement lanes per cycle.
// Ports:
//   clock, reset (async, active-low)
//   dispatch_valid/pc/dest_idx in, dispatch_tag/dispatch_stall out
//   src_tag in, src_ready/src_value out : operand lookups for reservation stations
//   complete_valid/tag/value/mispred/target in : functional-unit results
//   retire_valid/dest_idx/value out : register-file writes
//   squash/squash_pc out : pipeline flush and fetch redirect
//   rob_head, rob_tail, rob_count out : debug pointers and occupancy
module rob_nway
  import sys_defs::*;
#(
  parameter  int unsigned WAYS     = SYS_WAYS,
  parameter  int unsigned ROB_SIZE = SYS_ROB_SIZE,
  parameter  int unsigned XLEN     = SYS_XLEN,
  localparam int unsigned IDX      = $clog2(ROB_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WAYS-1:0]        dispatch_valid,
  input  logic [WAYS*XLEN-1:0]   dispatch_pc,
  input  logic [WAYS*5-1:0]      dispatch_dest_idx,
  output logic [WAYS*IDX-1:0]    dispatch_tag,
  output logic                   dispatch_stall,
  input  logic [2*WAYS*IDX-1:0]  src_tag,
  output logic [2*WAYS-1:0]      src_ready,
  output logic [2*WAYS*XLEN-1:0] src_value,
  input  logic [WAYS-1:0]        complete_valid,
  input  logic [WAYS*IDX-1:0]    complete_tag,
  input  logic [WAYS*XLEN-1:0]   complete_value,
  input  logic [WAYS-1:0]        complete_mispred,
  input  logic [WAYS*XLEN-1:0]   complete_target,
  output logic [WAYS-1:0]        retire_valid,
  output logic [WAYS*5-1:0]      retire_dest_idx,
  output logic [WAYS*XLEN-1:0]   retire_value,
  output logic                   squash,
  output logic [XLEN-1:0]        squash_pc,
  output logic [IDX-1:0]         rob_head,
  output logic [IDX-1:0]         rob_tail,
  output logic [IDX:0]           rob_count
);

  ROB_ENTRY       rob_q [ROB_SIZE];
  logic [IDX-1:0] head_q, tail_q;
  logic [IDX:0]   count_q;

  logic [IDX-1:0] head_idx [WAYS];
  ROB_ENTRY       disp_e   [WAYS];
  logic [WAYS-1:0] head_valid, head_completed, head_mispred;
  logic [WAYS-1:0] ret_lane, squash_sel, disp_lane;
  logic [IDX:0]    free_cnt, disp_cnt, ret_cnt;
  logic            disp_run;

  assign rob_head  = head_q;
  assign rob_tail  = tail_q;
  assign rob_count = count_q;

  // Stall looks only at current occupancy; same-cycle retirement does not help.
  always_comb begin
    free_cnt       = (IDX+1)'(ROB_SIZE) - count_q;
    dispatch_stall = free_cnt < (IDX+1)'(WAYS);
  end

  // Only the contiguous run of valid lanes starting at lane 0 allocates, so
  // tail advance and per-lane tags always agree.
  always_comb begin
    disp_lane = '0;
    disp_cnt  = '0;
    disp_run  = !dispatch_stall && !squash;
    for (int unsigned k = 0; k < WAYS; k++) begin
      dispatch_tag[k*IDX +: IDX] = tail_q + IDX'(k);
      disp_e[k]          = '0;
      disp_e[k].valid    = 1'b1;
      disp_e[k].pc       = dispatch_pc[k*XLEN +: XLEN];
      disp_e[k].dest_idx = dispatch_dest_idx[k*5 +: 5];
      if (disp_run && dispatch_valid[k]) begin
        disp_lane[k] = 1'b1;
        disp_cnt     = disp_cnt + (IDX+1)'(1);
      end else begin
        disp_run = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < WAYS; k++) begin
      head_idx[k]       = head_q + IDX'(k);
      head_valid[k]     = rob_q[head_idx[k]].valid;
      head_completed[k] = rob_q[head_idx[k]].completed;
      head_mispred[k]   = rob_q[head_idx[k]].mispred;
    end
  end

  rob_retire_sel #(
    .WAYS(WAYS)
  ) u_retire_sel (
    .head_valid     (head_valid),
    .head_completed (head_completed),
    .head_mispred   (head_mispred),
    .retire         (ret_lane),
    .squash_sel     (squash_sel)
  );

  always_comb begin
    ret_cnt         = '0;
    retire_valid    = ret_lane;
    retire_dest_idx = '0;
    retire_value    = '0;
    squash          = |squash_sel;
    squash_pc       = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      retire_value[k*XLEN +: XLEN] = rob_q[head_idx[k]].value;
      if (ret_lane[k]) begin
        ret_cnt                  = ret_cnt + (IDX+1)'(1);
        retire_dest_idx[k*5 +: 5] = rob_q[head_idx[k]].dest_idx;
      end
      if (squash_sel[k]) begin
        squash_pc = rob_q[head_idx[k]].target;
      end
    end
  end

  // Freed slots are zeroed, so a completed flag always implies a live entry.
  always_comb begin : src_lookup
    logic [IDX-1:0] t;
    logic           hit;
    src_ready = '0;
    src_value = '0;
    t         = '0;
    hit       = 1'b0;
    for (int unsigned j = 0; j < 2*WAYS; j++) begin
      t   = src_tag[j*IDX +: IDX];
      hit = 1'b0;
      if (rob_q[t].completed) begin
        src_ready[j]                 = 1'b1;
        src_value[j*XLEN +: XLEN]    = rob_q[t].value;
      end else begin
        for (int unsigned l = 0; l < WAYS; l++) begin
          if (!hit && complete_valid[l] && complete_tag[l*IDX +: IDX] == t) begin
            src_ready[j]              = 1'b1;
            src_value[j*XLEN +: XLEN] = complete_value[l*XLEN +: XLEN];
            hit                       = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (squash) begin
      for (int unsigned i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Completion, then retirement, then dispatch: dispatch only targets
      // free slots, so later writes never clobber live state.
      for (int unsigned l = 0; l < WAYS; l++) begin
        if (complete_valid[l] && rob_q[complete_tag[l*IDX +: IDX]].valid) begin
          rob_q[complete_tag[l*IDX +: IDX]].completed <= 1'b1;
          rob_q[complete_tag[l*IDX +: IDX]].value     <= complete_value[l*XLEN +: XLEN];
          rob_q[complete_tag[l*IDX +: IDX]].mispred   <= complete_mispred[l];
          rob_q[complete_tag[l*IDX +: IDX]].target    <= complete_target[l*XLEN +: XLEN];
        end
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (ret_lane[k]) rob_q[head_idx[k]] <= '0;
      end
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (disp_lane[k]) rob_q[tail_q + IDX'(k)] <= disp_e[k];
      end
      head_q  <= head_q + IDX'(ret_cnt);
      tail_q  <= tail_q + IDX'(disp_cnt);
      count_q <= count_q + disp_cnt - ret_cnt;
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Self-checking bench for rob_nway with a queue-based program-order model.
module tb_rob_nway;

  localparam int W  = 2;
  localparam int RS = 32;
  localparam int XL = 32;
  localparam int IX = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [W-1:0]    dispatch_valid;
  logic [W*XL-1:0] dispatch_pc;
  logic [W*5-1:0]  dispatch_dest_idx;
  logic [W*IX-1:0] dispatch_tag;
  logic            dispatch_stall;
  logic [2*W*IX-1:0] src_tag;
  logic [2*W-1:0]    src_ready;
  logic [2*W*XL-1:0] src_value;
  logic [W-1:0]    complete_valid;
  logic [W*IX-1:0] complete_tag;
  logic [W*XL-1:0] complete_value;
  logic [W-1:0]    complete_mispred;
  logic [W*XL-1:0] complete_target;
  logic [W-1:0]    retire_valid;
  logic [W*5-1:0]  retire_dest_idx;
  logic [W*XL-1:0] retire_value;
  logic            squash;
  logic [XL-1:0]   squash_pc;
  logic [IX-1:0]   rob_head, rob_tail;
  logic [IX:0]     rob_count;

  always #5 clock = ~clock;

  rob_nway #(.WAYS(W), .ROB_SIZE(RS), .XLEN(XL)) dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_pc(dispatch_pc),
    .dispatch_dest_idx(dispatch_dest_idx), .dispatch_tag(dispatch_tag),
    .dispatch_stall(dispatch_stall), .src_tag(src_tag), .src_ready(src_ready),
    .src_value(src_value), .complete_valid(complete_valid), .complete_tag(complete_tag),
    .complete_value(complete_value), .complete_mispred(complete_mispred),
    .complete_target(complete_target), .retire_valid(retire_valid),
    .retire_dest_idx(retire_dest_idx), .retire_value(retire_value), .squash(squash),
    .squash_pc(squash_pc), .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Program-order model: front of the queue is the oldest instruction.
  typedef struct {
    int         tag;
    bit         completed;
    bit         mispred;
    logic [31:0] value;
    logic [31:0] target;
    logic [4:0]  dest;
  } ent_t;

  ent_t mq[$];
  int   mhead = 0;
  int   mtail = 0;

  task automatic idle_inputs();
    dispatch_valid = '0; dispatch_pc = '0; dispatch_dest_idx = '0; src_tag = '0;
    complete_valid = '0; complete_tag = '0; complete_value = '0;
    complete_mispred = '0; complete_target = '0;
  endtask

  task automatic model_reset();
    mq.delete(); mhead = 0; mtail = 0;
  endtask

  function automatic bit model_stall();
    return (RS - mq.size()) < W;
  endfunction

  function automatic void model_retire(output logic [W-1:0] rv, output logic [W*5-1:0] rd,
                                       output logic [W*XL-1:0] rval, output logic sq,
                                       output logic [XL-1:0] sqpc);
    bit stop = 0;
    rv = '0; rd = '0; rval = '0; sq = 1'b0; sqpc = '0;
    for (int k = 0; k < W; k++) begin
      if (k < mq.size()) begin
        rval[k*XL +: XL] = mq[k].value;
        if (!stop && mq[k].completed) begin
          rv[k] = 1'b1;
          rd[k*5 +: 5] = mq[k].dest;
          if (mq[k].mispred) begin sq = 1'b1; sqpc = mq[k].target; stop = 1; end
        end else stop = 1;
      end else stop = 1;
    end
  endfunction

  function automatic logic [32:0] model_src(logic [4:0] tag);
    foreach (mq[i]) if (mq[i].tag == int'(tag) && mq[i].completed) return {1'b1, mq[i].value};
    for (int l = 0; l < W; l++)
      if (complete_valid[l] && complete_tag[l*IX +: IX] == tag) return {1'b1, complete_value[l*XL +: XL]};
    return '0;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // move to just after the DUT edge.
  task automatic model_edge();
    logic [W-1:0] rv; logic [W*5-1:0] rd; logic [W*XL-1:0] rval; logic sq; logic [XL-1:0] sqpc;
    bit stall;
    int nret;
    model_retire(rv, rd, rval, sq, sqpc);
    stall = model_stall();
    nret = $countones(rv);
    for (int l = 0; l < W; l++)
      if (complete_valid[l])
        foreach (mq[i])
          if (mq[i].tag == int'(complete_tag[l*IX +: IX])) begin
            mq[i].completed = 1; mq[i].value = complete_value[l*XL +: XL];
            mq[i].mispred = complete_mispred[l]; mq[i].target = complete_target[l*XL +: XL];
          end
    if (sq) model_reset();
    else begin
      repeat (nret) void'(mq.pop_front());
      mhead = (mhead + nret) % RS;
      if (!stall)
        for (int k = 0; k < W; k++) begin
          if (!dispatch_valid[k]) break;
          mq.push_back('{tag: mtail, completed: 0, mispred: 0, value: 0, target: 0,
                         dest: dispatch_dest_idx[k*5 +: 5]});
          mtail = (mtail + 1) % RS;
        end
    end
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n;
    for (int c = 0; c < 100 && mq.size() > 0; c++) begin
      idle_inputs();
      n = 0;
      foreach (mq[i])
        if (!mq[i].completed && n < W) begin
          complete_valid[n] = 1'b1; complete_tag[n*IX +: IX] = 5'(mq[i].tag);
          complete_value[n*XL +: XL] = $urandom; n++;
        end
      model_edge();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs(); #3;
    vectors++; if (rob_count !== 0) begin miscompares++; $display("FAIL reset_count got %0d want 0", rob_count); end
    vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", dispatch_stall); end
    vectors++; if (retire_valid !== '0) begin miscompares++; $display("FAIL reset_retire got %b want 0", retire_valid); end
    vectors++; if (squash !== 1'b0 || squash_pc !== '0) begin miscompares++; $display("FAIL reset_squash got %b/%h want 0/0", squash, squash_pc); end
    vectors++; if (rob_head !== 0 || rob_tail !== 0) begin miscompares++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", rob_head, rob_tail); end
    #4 reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    vectors++; if (rob_count !== 0 || retire_valid !== '0) begin miscompares++; $display("FAIL idle_after_reset count %0d retire %b want 0/0", rob_count, retire_valid); end
  endtask

  task automatic test_basic();
    idle_inputs(); dispatch_valid = 2'b11; dispatch_pc = {32'd8, 32'd4}; dispatch_dest_idx = {5'd5, 5'd3}; #1;
    vectors++; if (dispatch_tag !== {5'd1, 5'd0}) begin miscompares++; $display("FAIL basic_tag got %h want 020", dispatch_tag); end
    model_edge();
    idle_inputs(); complete_valid = 2'b01; complete_tag[4:0] = 5'd1; complete_value[31:0] = 32'd7; #1;
    vectors++; if (retire_valid !== 2'b00) begin miscompares++; $display("FAIL basic_early_retire got %b want 00", retire_valid); end
    model_edge();
    idle_inputs(); complete_valid = 2'b01; complete_tag[4:0] = 5'd0; complete_value[31:0] = 32'd9; #1;
    vectors++; if (retire_valid !== 2'b00) begin miscompares++; $display("FAIL basic_head_not_done got %b want 00", retire_valid); end
    model_edge();
    idle_inputs(); #1;
    vectors++; if (retire_valid !== 2'b11) begin miscompares++; $display("FAIL basic_retire got %b want 11", retire_valid); end
    vectors++; if (retire_dest_idx !== {5'd5, 5'd3}) begin miscompares++; $display("FAIL basic_dest got %h want %h", retire_dest_idx, {5'd5, 5'd3}); end
    vectors++; if (retire_value !== {32'd7, 32'd9}) begin miscompares++; $display("FAIL basic_value got %h want %h", retire_value, {32'd7, 32'd9}); end
    model_edge();
    vectors++; if (rob_count !== 0 || rob_head !== 5'd2 || rob_tail !== 5'd2) begin miscompares++; $display("FAIL basic_after count %0d head %0d tail %0d want 0/2/2", rob_count, rob_head, rob_tail); end
  endtask

  task automatic test_bypass();
    int t;
    idle_inputs(); dispatch_valid = 2'b01; dispatch_dest_idx[4:0] = 5'd7; model_edge();
    t = mq[0].tag;
    idle_inputs(); complete_valid = 2'b01; complete_tag[4:0] = 5'(t); complete_value[31:0] = 32'hAB;
    src_tag[4:0] = 5'(t); src_tag[9:5] = 5'(t + 1); #1;
    vectors++; if (src_ready[1:0] !== 2'b01) begin miscompares++; $display("FAIL bypass_ready got %b want 01", src_ready[1:0]); end
    vectors++; if (src_value[63:0] !== {32'd0, 32'hAB}) begin miscompares++; $display("FAIL bypass_value got %h want 000000ab", src_value[63:0]); end
    model_edge();
    idle_inputs(); src_tag[4:0] = 5'(t); #1;
    vectors++; if (src_ready[0] !== 1'b1 || src_value[31:0] !== 32'hAB) begin miscompares++; $display("FAIL stored_src got %b/%h want 1/ab", src_ready[0], src_value[31:0]); end
    vectors++; if (retire_valid !== 2'b01 || retire_value[31:0] !== 32'hAB) begin miscompares++; $display("FAIL bypass_retire got %b/%h want 01/ab", retire_valid, retire_value[31:0]); end
    model_edge();
    // Two lanes completing an unallocated tag: lowest lane feeds the bypass,
    // neither allocates or marks anything.
    idle_inputs(); complete_valid = 2'b11; complete_tag = {5'd20, 5'd20};
    complete_value = {32'h22, 32'h11}; src_tag[14:10] = 5'd20; #1;
    vectors++; if (src_ready[2] !== 1'b1 || src_value[95:64] !== 32'h11) begin miscompares++; $display("FAIL bypass_priority got %b/%h want 1/11", src_ready[2], src_value[95:64]); end
    model_edge();
    idle_inputs(); src_tag[4:0] = 5'd20; #1;
    vectors++; if (src_ready[0] !== 1'b0 || src_value[31:0] !== '0 || rob_count !== 0) begin miscompares++; $display("FAIL invalid_complete got %b/%h/%0d want 0/0/0", src_ready[0], src_value[31:0], rob_count); end
  endtask

  task automatic test_fill_wrap();
    int h0;
    h0 = mhead;
    while (mq.size() < 30) begin
      idle_inputs(); dispatch_valid = 2'b11; dispatch_pc = {$urandom, $urandom}; #1;
      vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL fill_stall count %0d got 1 want 0", rob_count); end
      model_edge();
    end
    vectors++; if (rob_count !== 30 || rob_tail !== 5'((h0 + 30) % RS)) begin miscompares++; $display("FAIL fill_30 count %0d tail %0d want 30/%0d", rob_count, rob_tail, (h0 + 30) % RS); end
    idle_inputs(); dispatch_valid = 2'b11; #1;
    vectors++; if (dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL stall_at_30 got 1 want 0"); end
    model_edge();
    idle_inputs(); dispatch_valid = 2'b11; #1;
    vectors++; if (rob_count !== 32 || dispatch_stall !== 1'b1 || rob_head !== rob_tail) begin miscompares++; $display("FAIL full count %0d stall %b head %0d tail %0d want 32/1/equal", rob_count, dispatch_stall, rob_head, rob_tail); end
    model_edge();
    vectors++; if (rob_count !== 32) begin miscompares++; $display("FAIL full_ignore count %0d want 32", rob_count); end
    for (int r = 0; r < 2; r++) begin
      idle_inputs(); complete_valid = 2'b11;
      complete_tag = {5'(mq[1].tag), 5'(mq[0].tag)}; complete_value = {$urandom, $urandom};
      model_edge();
      idle_inputs(); dispatch_valid = 2'b11; #1;
      vectors++; if (retire_valid !== 2'b11) begin miscompares++; $display("FAIL fill_retire%0d got %b want 11", r, retire_valid); end
      vectors++; if (dispatch_stall !== (r == 0)) begin miscompares++; $display("FAIL fill_retire_stall%0d got %b want %b", r, dispatch_stall, r == 0); end
      model_edge();
      vectors++; if (rob_count !== 30 || rob_head !== 5'((h0 + 2 + 2*r) % RS) || rob_tail !== 5'((h0 + 2*r) % RS)) begin
        miscompares++; $display("FAIL fill_after%0d count %0d head %0d tail %0d want 30/%0d/%0d", r, rob_count, rob_head, rob_tail, (h0 + 2 + 2*r) % RS, (h0 + 2*r) % RS); end
    end
    drain();
    vectors++; if (rob_count !== 0 || mq.size() != 0) begin miscompares++; $display("FAIL drain count %0d want 0", rob_count); end
  endtask

  task automatic test_mispred();
    idle_inputs(); dispatch_valid = 2'b11; model_edge();
    idle_inputs(); complete_valid = 2'b11; complete_tag = {5'(mq[1].tag), 5'(mq[0].tag)};
    complete_mispred = 2'b01; complete_target[31:0] = 32'h100; complete_value = {32'h55, 32'h44};
    model_edge();
    idle_inputs(); dispatch_valid = 2'b11; #1;
    vectors++; if (retire_valid !== 2'b01) begin miscompares++; $display("FAIL mp_retire got %b want 01", retire_valid); end
    vectors++; if (squash !== 1'b1 || squash_pc !== 32'h100) begin miscompares++; $display("FAIL mp_squash got %b/%h want 1/100", squash, squash_pc); end
    vectors++; if (retire_dest_idx[9:5] !== 5'd0) begin miscompares++; $display("FAIL mp_lane1_dest got %0d want 0", retire_dest_idx[9:5]); end
    model_edge();
    vectors++; if (rob_count !== 0 || rob_head !== 0 || rob_tail !== 0 || squash !== 1'b0) begin miscompares++; $display("FAIL mp_flush count %0d head %0d tail %0d squash %b want 0/0/0/0", rob_count, rob_head, rob_tail, squash); end
  endtask

  task automatic test_random();
    logic [W-1:0] rv; logic [W*5-1:0] rd; logic [W*XL-1:0] rval; logic sq; logic [XL-1:0] sqpc;
    logic [32:0] e;
    int cand[$]; int pick; int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle_inputs();
      r = $urandom_range(0, 3);
      dispatch_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      dispatch_pc = {$urandom, $urandom}; dispatch_dest_idx = 10'($urandom);
      cand.delete();
      foreach (mq[i]) if (!mq[i].completed) cand.push_back(i);
      for (int l = 0; l < W; l++) begin
        if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
          pick = $urandom_range(0, cand.size() - 1);
          complete_valid[l] = 1'b1; complete_tag[l*IX +: IX] = 5'(mq[cand[pick]].tag);
          cand.delete(pick);
        end else if ($urandom_range(0, 7) == 0 && mq.size() < RS) begin
          complete_valid[l] = 1'b1; complete_tag[l*IX +: IX] = 5'(mtail);
        end
        complete_value[l*XL +: XL] = $urandom; complete_target[l*XL +: XL] = $urandom;
        complete_mispred[l] = ($urandom_range(0, 15) == 0);
      end
      for (int j = 0; j < 2*W; j++) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1) src_tag[j*IX +: IX] = 5'(mq[$urandom_range(0, mq.size() - 1)].tag);
        else if (complete_valid[0] && $urandom_range(0, 3) == 0) src_tag[j*IX +: IX] = complete_tag[IX-1:0];
        else src_tag[j*IX +: IX] = 5'($urandom);
      end
      #1;
      model_retire(rv, rd, rval, sq, sqpc);
      vectors++; if (dispatch_stall !== model_stall()) begin miscompares++; $display("FAIL rnd_stall cyc %0d got %b want %b", cyc, dispatch_stall, model_stall()); end
      vectors++; if (dispatch_tag !== {5'((mtail + 1) % RS), 5'(mtail)}) begin miscompares++; $display("FAIL rnd_tag cyc %0d got %h tail %0d", cyc, dispatch_tag, mtail); end
      vectors++; if (rob_count !== mq.size() || rob_head !== 5'(mhead) || rob_tail !== 5'(mtail)) begin
        miscompares++; $display("FAIL rnd_ptrs cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", cyc, rob_count, rob_head, rob_tail, mq.size(), mhead, mtail); end
      vectors++; if (retire_valid !== rv || retire_dest_idx !== rd || retire_value !== rval) begin
        miscompares++; $display("FAIL rnd_retire cyc %0d got %b/%h/%h want %b/%h/%h", cyc, retire_valid, retire_dest_idx, retire_value, rv, rd, rval); end
      vectors++; if (squash !== sq || squash_pc !== sqpc) begin miscompares++; $display("FAIL rnd_squash cyc %0d got %b/%h want %b/%h", cyc, squash, squash_pc, sq, sqpc); end
      for (int j = 0; j < 2*W; j++) begin
        e = model_src(src_tag[j*IX +: IX]);
        vectors++; if (src_ready[j] !== e[32] || src_value[j*XL +: XL] !== e[31:0]) begin
          miscompares++; $display("FAIL rnd_src%0d cyc %0d got %b/%h want %b/%h", j, cyc, src_ready[j], src_value[j*XL +: XL], e[32], e[31:0]); end
      end
      model_edge();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    drain();
    while (mq.size() < 10) begin idle_inputs(); dispatch_valid = 2'b11; model_edge(); end
    idle_inputs(); complete_valid = 2'b11; complete_tag = {5'(mq[1].tag), 5'(mq[0].tag)};
    complete_value = {32'h66, 32'h77}; model_edge();
    idle_inputs(); dispatch_valid = 2'b11; #1;
    vectors++; if (rob_count !== 10 || retire_valid !== 2'b11) begin miscompares++; $display("FAIL pre_reset count %0d retire %b want 10/11", rob_count, retire_valid); end
    #2 reset = 1'b0; #1;
    vectors++; if (rob_count !== 0 || rob_head !== 0 || rob_tail !== 0) begin miscompares++; $display("FAIL mid_reset count %0d head %0d tail %0d want 0/0/0", rob_count, rob_head, rob_tail); end
    vectors++; if (retire_valid !== 2'b00 || retire_dest_idx !== '0 || dispatch_stall !== 1'b0) begin miscompares++; $display("FAIL mid_reset_out retire %b dest %h stall %b want 0/0/0", retire_valid, retire_dest_idx, dispatch_stall); end
    @(posedge clock); #2 reset = 1'b1;
    model_reset(); idle_inputs();
    @(posedge clock); #1;
    vectors++; if (rob_count !== 0 || retire_valid !== 2'b00) begin miscompares++; $display("FAIL post_reset count %0d retire %b want 0/00", rob_count, retire_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_bypass();
    test_fill_wrap();
    test_mispred();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
